// File: rtl/wb_commit_if.sv
// Writeback commit port bundle: MEM-stage offer, dmem load response,
// register-file write port and hazard-unit status.
interface wb_commit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      in_rd;
    logic            in_reg_write;
    logic            in_is_load;
    logic [2:0]      in_funct3;
    logic [1:0]      in_addr_lo;
    logic [XLEN-1:0] in_result;
    logic            dmem_rvalid;
    logic [XLEN-1:0] dmem_rdata;
    logic [4:0]      rd_wb;
    logic [XLEN-1:0] rd_wb_data;
    logic            RegWrite_WB;
    logic            pend_valid;
    logic [4:0]      pend_rd;
    logic            load_err;

    modport slave (
        input  in_valid, in_rd, in_reg_write, in_is_load, in_funct3,
               in_addr_lo, in_result, dmem_rvalid, dmem_rdata,
        output in_ready, rd_wb, rd_wb_data, RegWrite_WB, pend_valid,
               pend_rd, load_err
    );

    modport master (
        output in_valid, in_rd, in_reg_write, in_is_load, in_funct3,
               in_addr_lo, in_result, dmem_rvalid, dmem_rdata,
        input  in_ready, rd_wb, rd_wb_data, RegWrite_WB, pend_valid,
               pend_rd, load_err
    );
endinterface

// File: rtl/wb_commit_unit.sv
// RV32I writeback commit stage: commits ALU results, waits for load data
// with a timeout, formats it and drives a registered register-file write.
module wb_commit_unit #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    wb_commit_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic {
        IDLE,
        LOAD_WAIT
    } state_e;

    state_e state_q, state_d;

    logic [TW-1:0]   timer_q, timer_d;
    logic [4:0]      lrd_q, lrd_d;
    logic            lrw_q, lrw_d;
    logic [2:0]      lf3_q, lf3_d;
    logic [1:0]      llo_q, llo_d;
    logic            we_q, we_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            err_q, err_d;
    logic            pv_q, pv_d;
    logic [4:0]      prd_q, prd_d;

    function automatic logic [XLEN-1:0] fmt_load(input logic [2:0] f3,
                                                 input logic [1:0] lo,
                                                 input logic [XLEN-1:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lo, 3'b000} +: 8];
        h = lo[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{(XLEN-8){b[7]}}, b};
            3'b001:  return {{(XLEN-16){h[15]}}, h};
            3'b100:  return {{(XLEN-8){1'b0}}, b};
            3'b101:  return {{(XLEN-16){1'b0}}, h};
            default: return w;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin : state_reg
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            IDLE:      if (bus.in_valid && bus.in_is_load) state_d = LOAD_WAIT;
            LOAD_WAIT: if (bus.dmem_rvalid || timer_q == TLAST) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin : outputs
        bus.in_ready = (state_q == IDLE);
        we_d    = 1'b0;
        err_d   = 1'b0;
        rd_d    = rd_q;
        data_d  = data_q;
        timer_d = timer_q;
        lrd_d   = lrd_q;
        lrw_d   = lrw_q;
        lf3_d   = lf3_q;
        llo_d   = llo_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.in_is_load) begin
                        lrd_d   = bus.in_rd;
                        lrw_d   = bus.in_reg_write;
                        lf3_d   = bus.in_funct3;
                        llo_d   = bus.in_addr_lo;
                        timer_d = '0;
                    end else if (bus.in_reg_write && bus.in_rd != '0) begin
                        we_d   = 1'b1;
                        rd_d   = bus.in_rd;
                        data_d = bus.in_result;
                    end
                end
            end
            LOAD_WAIT: begin
                // A response on the final timer cycle still commits.
                if (bus.dmem_rvalid) begin
                    if (lrw_q && lrd_q != '0) begin
                        we_d   = 1'b1;
                        rd_d   = lrd_q;
                        data_d = fmt_load(lf3_q, llo_q, bus.dmem_rdata);
                    end
                end else if (timer_q == TLAST) begin
                    err_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: ;
        endcase
        pv_d  = (state_d == LOAD_WAIT);
        prd_d = pv_d ? lrd_d : '0;
    end

    always_ff @(posedge clk or posedge rst) begin : datapath_reg
        if (rst) begin
            timer_q <= '0;
            lrd_q   <= '0;
            lrw_q   <= 1'b0;
            lf3_q   <= '0;
            llo_q   <= '0;
            we_q    <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            pv_q    <= 1'b0;
            prd_q   <= '0;
        end else begin
            timer_q <= timer_d;
            lrd_q   <= lrd_d;
            lrw_q   <= lrw_d;
            lf3_q   <= lf3_d;
            llo_q   <= llo_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            err_q   <= err_d;
            pv_q    <= pv_d;
            prd_q   <= prd_d;
        end
    end

    assign bus.RegWrite_WB = we_q;
    assign bus.rd_wb       = rd_q;
    assign bus.rd_wb_data  = data_q;
    assign bus.load_err    = err_q;
    assign bus.pend_valid  = pv_q;
    assign bus.pend_rd     = prd_q;
endmodule

// File: doc/wb_commit_unit.md
# wb_commit_unit

Writeback commit stage of the RV32I pipeline, and the producer side of the register-file write port. It accepts retiring instructions from the MEM stage and buffers loads until the data-memory response returns. It formats load data (byte/half extraction, sign/zero extension) and drives a registered one-cycle write pulse on rd_wb / rd_wb_data / RegWrite_WB. It also exports pending-load status for the hazard unit.

## Interface
- XLEN, 32: datapath width; only 32 is supported.
- TIMEOUT, 64: maximum number of LOAD_WAIT cycles before the load is abandoned; must be at least 2.
- clk  in  1  clock. All state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  MEM stage offers an instruction.
- in_ready  out  1  stage can accept; a transfer occurs when in_valid && in_ready at a rising edge.
- in_rd  in  5  destination register.
- in_reg_write  in  1  instruction writes rd.
- in_is_load  in  1  instruction is a load; its result comes from dmem.
- in_funct3  in  3  load type.
- in_addr_lo  in  2  load byte address bits [1:0].
- in_result  in  32  ALU/PC+4 result, used for non-loads.
- dmem_rvalid  in  1  load response valid (single-cycle pulse).
- dmem_rdata  in  32  aligned load word.
- rd_wb  out  5  write address.
- rd_wb_data  out  32  write data.
- RegWrite_WB  out  1  write strobe, one cycle per committed write.
- pend_valid  out  1  a load is outstanding (state LOAD_WAIT).
- pend_rd  out  5  rd of the outstanding load; 0 when pend_valid=0.
- load_err  out  1  one-cycle pulse when a load times out.

## Operation
- States:
  - IDLE: in_ready=1.
  - LOAD_WAIT: in_ready=0, pend_valid=1, timer running.
- IDLE, non-load transfer:
  - Next cycle: RegWrite_WB = in_reg_write && in_rd!=0, rd_wb=in_rd, rd_wb_data=in_result.
  - Stay in IDLE, so back-to-back non-loads commit once per cycle.
- IDLE, load transfer:
  - Latch rd, reg_write, funct3, addr_lo.
  - Clear the timer and go to LOAD_WAIT.
  - No write pulse is produced next cycle.
- LOAD_WAIT, dmem_rvalid=1:
  - Register the formatted data.
  - Next cycle: RegWrite_WB = latched reg_write && rd!=0. A load to x0 consumes the response without writing.
  - Go to IDLE.
- LOAD_WAIT, no response:
  - Timer increments each cycle.
  - When the timer equals TIMEOUT-1 and dmem_rvalid=0, pulse load_err next cycle, write nothing, go to IDLE.
  - If rvalid arrives in that same cycle, rvalid wins: the write commits and there is no error.
- Formatting by funct3, with byte lane = addr_lo:
  - 000 LB: sign-extend the byte.
  - 001 LH: sign-extend the half at addr_lo[1].
  - 010 LW: full word.
  - 100 LBU: zero-extend the byte.
  - 101 LHU: zero-extend the half.
  - 011/110/111: treated as LW.
  - addr_lo[0] is ignored for halves; misalignment is trapped upstream.
- dmem_rvalid in IDLE is ignored; no state change and no write.
- Outputs rd_wb and rd_wb_data hold their last values when RegWrite_WB=0.

## Timing
- Reset values, applied immediately on rst high:
  - RegWrite_WB=0, rd_wb=0, rd_wb_data=0.
  - load_err=0, pend_valid=0, pend_rd=0.
  - state=IDLE, timer=0.
- Reset mid-load drops the load; a response arriving after rst deasserts is ignored as stray.
- Non-load latency: transfer at edge N, write visible during cycle N+1, committed to GPR at edge N+1.
- Load latency: write visible the cycle after the rvalid edge.
- in_ready returns to 1 in the same cycle as the load's write pulse, so a new transfer may coincide with the commit.
- in_ready is purely a function of state; it never depends on in_valid combinationally.
- pend_valid/pend_rd are registered and assert the cycle after the load transfer.

## Test plan
- Reset: assert rst asynchronously mid-cycle -> all outputs 0 immediately; state IDLE.
- Back-to-back non-loads:
  - Stimulus: rd=5, result=0x11; then rd=6, result=0x22; then rd=0, result=0x33, on consecutive cycles.
  - Response: writes (5,0x11), (6,0x22) on consecutive cycles, then RegWrite_WB=0 for rd=0.
- Load formatting with dmem_rdata=0x80FF7F01:
  - LB at addr_lo=3 -> 0xFFFFFF80.
  - LBU at 3 -> 0x00000080.
  - LH at 2 -> 0xFFFF80FF.
  - LHU at 0 -> 0x00007F01.
  - LW -> 0x80FF7F01.
- Load stall:
  - Stimulus: LW rd=7, rvalid after 5 cycles.
  - Response: in_ready=0 and pend_valid=1 with pend_rd=7 for 5 cycles; write (7,data) one cycle after rvalid; a new ALU op accepted in that same cycle commits on the next cycle.
- Timeout with TIMEOUT=4:
  - No response -> load_err pulse, no write, in_ready=1.
  - Rerun with rvalid exactly on the timeout cycle -> write occurs, load_err stays 0.
- Stray response and reset mid-load:
  - dmem_rvalid in IDLE -> no write.
  - rst during LOAD_WAIT, then rvalid after rst deasserts -> no write, pend_valid=0.
